// File: rtl/ntt_tile_mem.sv
// ============================================================================
// Module      : ntt_tile_mem
// Description : Memory responder for the NTT wrapper. Provides a W bank and
//               ping-pong X/result banks, with a host preload/dump port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_tile_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ARRAY_ROWS = 4,
  parameter int DEPTH      = 64
) (
  input  logic                               clk,
  input  logic                               srstn,
  input  logic [31:0]                        w_addr,
  input  logic                               mem_read_w,
  output logic [DATA_WIDTH*ARRAY_ROWS-1:0]   w_rdata,
  input  logic [31:0]                        x_addr,
  input  logic                               mem_read_x,
  output logic [DATA_WIDTH*ARRAY_ROWS-1:0]   x_rdata,
  input  logic [31:0]                        mem_write_addr,
  input  logic                               mem_write,
  input  logic [DATA_WIDTH*ARRAY_ROWS-1:0]   mem_wdata,
  input  logic                               swap,
  input  logic                               host_en,
  input  logic                               host_we,
  input  logic [1:0]                         host_bank,
  input  logic [$clog2(DEPTH)-1:0]           host_addr,
  input  logic [DATA_WIDTH*ARRAY_ROWS-1:0]   host_wdata,
  output logic [DATA_WIDTH*ARRAY_ROWS-1:0]   host_rdata,
  output logic                               host_stall,
  input  logic                               err_clr,
  output logic                               err_oob,
  output logic                               err_host,
  output logic                               x_sel,
  output logic [$clog2(DEPTH):0]             wr_count
);

  localparam int BPW    = DATA_WIDTH * ARRAY_ROWS / 8;
  localparam int WORD_W = DATA_WIDTH * ARRAY_ROWS;
  localparam int AW     = $clog2(DEPTH);

  localparam logic [31:0]   C_BPW   = 32'(BPW);
  localparam logic [31:0]   C_DEPTH = 32'(DEPTH);
  localparam logic [AW:0]   C_SAT   = (AW+1)'(DEPTH);

  logic [WORD_W-1:0] r_mem_w [DEPTH];
  logic [WORD_W-1:0] r_mem_p [2][DEPTH];

  logic [WORD_W-1:0] r_w_rdata;
  logic [WORD_W-1:0] r_x_rdata;
  logic [WORD_W-1:0] r_host_rdata;
  logic              r_err_oob;
  logic              r_err_host;
  logic              r_x_sel;
  logic [AW:0]       r_wr_count;

  logic [31:0]       w_w_word;
  logic [31:0]       w_x_word;
  logic [31:0]       w_wr_word;
  logic              w_w_ok;
  logic              w_x_ok;
  logic              w_wr_ok;
  logic              w_core_wr;
  logic              w_host_stall;
  logic              w_host_ok;
  logic              w_host_rsvd;
  logic              w_host_phys;
  logic              w_oob_set;

  assign w_w_word  = w_addr / C_BPW;
  assign w_x_word  = x_addr / C_BPW;
  assign w_wr_word = mem_write_addr / C_BPW;

  assign w_w_ok  = ((w_addr % C_BPW) == 32'd0) && (w_w_word < C_DEPTH);
  assign w_x_ok  = ((x_addr % C_BPW) == 32'd0) && (w_x_word < C_DEPTH);
  assign w_wr_ok = ((mem_write_addr % C_BPW) == 32'd0) && (w_wr_word < C_DEPTH);

  assign w_core_wr = mem_write && w_wr_ok;
  assign w_oob_set = (mem_read_w && !w_w_ok) || (mem_read_x && !w_x_ok) ||
                     (mem_write && !w_wr_ok);

  // A core request occupies its bank even if its address turns out invalid
  always_comb begin
    w_host_stall = 1'b0;
    if (host_en && host_bank != 2'd3) begin
      w_host_stall = swap ||
                     (host_bank == 2'd0 && mem_read_w) ||
                     (host_bank == 2'd1 && mem_read_x) ||
                     (host_bank == 2'd2 && mem_write);
    end
  end

  assign w_host_rsvd = host_en && host_bank == 2'd3;
  assign w_host_ok   = host_en && !w_host_stall && host_bank != 2'd3;
  assign w_host_phys = (host_bank == 2'd1) ? r_x_sel : ~r_x_sel;

  // Bank storage: no reset, contents survive srstn
  always_ff @(posedge clk) begin
    if (srstn) begin
      if (w_host_ok && host_we && host_bank == 2'd0)
        r_mem_w[host_addr] <= host_wdata;
      if (w_host_ok && host_we && host_bank != 2'd0)
        r_mem_p[w_host_phys][host_addr] <= host_wdata;
      if (w_core_wr)
        r_mem_p[~r_x_sel][w_wr_word[AW-1:0]] <= mem_wdata;
    end
  end

  // Reads sample the array before this edge's writes land, giving read-first
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_w_rdata    <= '0;
      r_x_rdata    <= '0;
      r_host_rdata <= '0;
      r_err_oob    <= 1'b0;
      r_err_host   <= 1'b0;
      r_x_sel      <= 1'b0;
      r_wr_count   <= '0;
    end else begin
      if (mem_read_w)
        r_w_rdata <= w_w_ok ? r_mem_w[w_w_word[AW-1:0]] : '0;
      if (mem_read_x)
        r_x_rdata <= w_x_ok ? r_mem_p[r_x_sel][w_x_word[AW-1:0]] : '0;

      if (w_host_rsvd)
        r_host_rdata <= '0;
      else if (w_host_ok && !host_we)
        r_host_rdata <= (host_bank == 2'd0) ? r_mem_w[host_addr]
                                            : r_mem_p[w_host_phys][host_addr];

      if (w_oob_set)
        r_err_oob <= 1'b1;
      else if (err_clr)
        r_err_oob <= 1'b0;

      if (w_host_rsvd)
        r_err_host <= 1'b1;
      else if (err_clr)
        r_err_host <= 1'b0;

      if (swap) begin
        r_x_sel    <= ~r_x_sel;
        r_wr_count <= '0;
      end else if (w_core_wr && r_wr_count != C_SAT) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
    end
  end

  assign w_rdata    = r_w_rdata;
  assign x_rdata    = r_x_rdata;
  assign host_rdata = r_host_rdata;
  assign host_stall = w_host_stall;
  assign err_oob    = r_err_oob;
  assign err_host   = r_err_host;
  assign x_sel      = r_x_sel;
  assign wr_count   = r_wr_count;

endmodule

`default_nettype wire

// File: tb/tb_ntt_tile_mem.sv
// ============================================================================
// Module      : tb_ntt_tile_mem
// Description : Directed self-checking bench for ntt_tile_mem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ntt_tile_mem;

  localparam int WW = 128;
  localparam logic [WW-1:0] C_A = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
  localparam logic [WW-1:0] C_D = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [WW-1:0] C_B = 128'h0000_0000_0000_0000_0000_0000_0000_0B0B;
  localparam logic [WW-1:0] C_C = 128'h0000_0000_0000_0000_0000_0000_0000_0C0C;
  localparam logic [WW-1:0] C_E = 128'h0000_0000_0000_0000_0000_0000_0000_0E0E;
  localparam logic [WW-1:0] C_F = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

  logic          clk;
  logic          srstn;
  logic [31:0]   w_addr;
  logic          mem_read_w;
  logic [WW-1:0] w_rdata;
  logic [31:0]   x_addr;
  logic          mem_read_x;
  logic [WW-1:0] x_rdata;
  logic [31:0]   mem_write_addr;
  logic          mem_write;
  logic [WW-1:0] mem_wdata;
  logic          swap;
  logic          host_en;
  logic          host_we;
  logic [1:0]    host_bank;
  logic [5:0]    host_addr;
  logic [WW-1:0] host_wdata;
  logic [WW-1:0] host_rdata;
  logic          host_stall;
  logic          err_clr;
  logic          err_oob;
  logic          err_host;
  logic          x_sel;
  logic [6:0]    wr_count;

  int n_cmp = 0;
  int n_err = 0;

  ntt_tile_mem #(.DATA_WIDTH(32), .ARRAY_ROWS(4), .DEPTH(64)) dut (
    .clk(clk), .srstn(srstn),
    .w_addr(w_addr), .mem_read_w(mem_read_w), .w_rdata(w_rdata),
    .x_addr(x_addr), .mem_read_x(mem_read_x), .x_rdata(x_rdata),
    .mem_write_addr(mem_write_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .swap(swap),
    .host_en(host_en), .host_we(host_we), .host_bank(host_bank),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_stall(host_stall),
    .err_clr(err_clr), .err_oob(err_oob), .err_host(err_host),
    .x_sel(x_sel), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    mem_read_w = 0; mem_read_x = 0; mem_write = 0; swap = 0;
    host_en = 0; host_we = 0; err_clr = 0;
  endtask

  initial begin
    srstn = 0; w_addr = 0; x_addr = 0; mem_write_addr = 0; mem_wdata = '0;
    host_bank = 0; host_addr = 0; host_wdata = '0;
    idle();
    tick(); tick();
    srstn = 1;

    check("rst_w_rdata", w_rdata, '0);
    check("rst_x_rdata", x_rdata, '0);
    check("rst_host_rdata", host_rdata, '0);
    check("rst_x_sel", {127'd0, x_sel}, '0);
    check("rst_wr_count", {121'd0, wr_count}, '0);
    check("rst_errs", {126'd0, err_oob, err_host}, '0);

    // Preload X (physical bank 0) word 5, read it, swap, then reset
    host_en = 1; host_we = 1; host_bank = 2'd1; host_addr = 6'd5; host_wdata = C_A;
    tick(); idle();
    mem_read_x = 1; x_addr = 32'd80;
    tick(); idle();
    check("pre_rst_x_read", x_rdata, C_A);
    swap = 1;
    tick(); idle();
    check("pre_rst_x_sel", {127'd0, x_sel}, 128'd1);
    srstn = 0;
    tick(); srstn = 1;
    check("rst2_x_rdata", x_rdata, '0);
    check("rst2_x_sel", {127'd0, x_sel}, '0);
    mem_read_x = 1; x_addr = 32'd80;
    tick(); idle();
    check("rst2_contents_kept", x_rdata, C_A);

    // Read latency on W
    host_en = 1; host_we = 1; host_bank = 2'd0; host_addr = 6'd3; host_wdata = C_D;
    tick(); idle();
    mem_read_w = 1; w_addr = 32'd48;
    tick(); idle();
    check("w_read_latency", w_rdata, C_D);
    tick();
    check("w_read_hold", w_rdata, C_D);

    // Fill result bank, saturate wr_count, swap
    for (int k = 0; k < 64; k++) begin
      mem_write = 1; mem_write_addr = 32'(k * 16); mem_wdata = 128'(k);
      tick();
    end
    idle();
    check("fill_wr_count", {121'd0, wr_count}, 128'd64);
    mem_write = 1; mem_write_addr = 32'd0; mem_wdata = '0;
    tick(); idle();
    check("wr_count_sat", {121'd0, wr_count}, 128'd64);
    swap = 1;
    tick(); idle();
    check("swap_x_sel", {127'd0, x_sel}, 128'd1);
    check("swap_wr_count", {121'd0, wr_count}, '0);
    mem_read_x = 1; x_addr = 32'h3F0;
    tick(); idle();
    check("pingpong_x63", x_rdata, 128'd63);

    // Collision: X word 2 read while result word 2 written (different banks)
    mem_read_x = 1; x_addr = 32'd32; mem_write = 1; mem_write_addr = 32'd32; mem_wdata = C_B;
    tick(); idle();
    check("coll_x_read", x_rdata, 128'd2);
    check("coll_wr_count", {121'd0, wr_count}, 128'd1);
    // Write in the swap cycle goes to the pre-swap result bank, uncounted
    mem_read_x = 1; x_addr = 32'd32; mem_write = 1; mem_write_addr = 32'd32; mem_wdata = C_C;
    swap = 1;
    tick(); idle();
    check("swapcyc_x_read_old", x_rdata, 128'd2);
    check("swapcyc_x_sel", {127'd0, x_sel}, '0);
    check("swapcyc_wr_count", {121'd0, wr_count}, '0);
    mem_read_x = 1; x_addr = 32'd32;
    host_en = 1; host_we = 0; host_bank = 2'd2; host_addr = 6'd2;
    tick(); idle();
    check("post_swap_x_new", x_rdata, C_C);
    check("host_read_result", host_rdata, 128'd2);
    host_en = 1; host_we = 1; host_bank = 2'd2; host_addr = 6'd10; host_wdata = C_E;
    tick(); idle();
    check("host_wr_no_count", {121'd0, wr_count}, '0);

    // Error flags
    mem_read_w = 1; w_addr = 32'd8; mem_read_x = 1; x_addr = 32'd1024;
    tick(); idle();
    check("oob_w_rdata", w_rdata, '0);
    check("oob_x_rdata", x_rdata, '0);
    check("oob_flag", {127'd0, err_oob}, 128'd1);
    check("oob_no_host_err", {127'd0, err_host}, '0);
    err_clr = 1;
    tick(); idle();
    check("oob_clr", {127'd0, err_oob}, '0);
    err_clr = 1; mem_write = 1; mem_write_addr = 32'd1024; mem_wdata = C_F;
    tick(); idle();
    check("oob_set_wins", {127'd0, err_oob}, 128'd1);
    check("oob_wr_not_counted", {121'd0, wr_count}, '0);
    host_en = 1; host_we = 0; host_bank = 2'd2; host_addr = 6'd0;
    tick(); idle();
    check("oob_wr_discarded", host_rdata, '0);
    host_en = 1; host_we = 0; host_bank = 2'd2; host_addr = 6'd10;
    tick(); idle();
    check("host_wr_bank2", host_rdata, C_E);
    host_en = 1; host_we = 0; host_bank = 2'd3; host_addr = 6'd0;
    #1;
    check("rsvd_no_stall", {127'd0, host_stall}, '0);
    tick(); idle();
    check("rsvd_rdata_zero", host_rdata, '0);
    check("rsvd_err_host", {127'd0, err_host}, 128'd1);
    err_clr = 1;
    tick(); idle();
    check("err_clr_both", {126'd0, err_oob, err_host}, '0);

    // Host stall against a core X read, then accepted when idle
    host_en = 1; host_we = 0; host_bank = 2'd1; host_addr = 6'd5;
    mem_read_x = 1; x_addr = 32'd80;
    #1;
    check("stall_active", {127'd0, host_stall}, 128'd1);
    tick();
    check("stall_rdata_held", host_rdata, '0);
    check("stall_core_read", x_rdata, C_A);
    mem_read_x = 0;
    #1;
    check("stall_released", {127'd0, host_stall}, '0);
    tick(); idle();
    check("stall_retry_data", host_rdata, C_A);
    host_en = 1; host_bank = 2'd0; swap = 1;
    #1;
    check("stall_on_swap", {127'd0, host_stall}, 128'd1);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
